tatzel_trim_sar: RTL

Parametrised successive-approximation trim controller for the analog reference macros in the tatzel tile. It holds one trim code per reference channel and drives all codes continuously to the analog trim DACs. On request it runs a binary search on one selected channel, using the analog comparator output that indicates whether the reference is below target. It replaces hand-set trim pins with a self-calibrating, multi-channel, software-overridable trim path.

---
 rtl/tatzel_trim_pkg.sv | 16 +
 rtl/tatzel_sync2.sv | 21 ++
 rtl/tatzel_trim_sar.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tatzel_trim_pkg.sv
// Shared types and helpers for the tatzel reference trim controller.
package tatzel_trim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } trim_state_e;

  // LSB position of channel ch inside a packed array of w-bit codes.
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/tatzel_sync2.sv
// Two-flop synchroniser for a single asynchronous level signal.
module tatzel_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tatzel_trim_sar.sv
// Multi-channel SAR trim controller: holds one trim code per reference channel
// and runs a comparator-driven binary search on one channel on request.
//
//   state  | meaning
//   IDLE   | waiting; accepts start or a manual code write
//   SETTLE | trial code applied, settle down-counter running
//   SAMPLE | synced comparator decides the current trial bit
//   DONE   | result/sat captured, done pulse high for this cycle
module tatzel_trim_sar
  import tatzel_trim_pkg::*;
#(
  parameter int TRIM_W     = 6,
  parameter int N_CH       = 2,
  parameter int SETTLE_CYC = 4,
  parameter int RESET_CODE = 1 << (TRIM_W - 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
  input  logic                                     cmp_in,
  input  logic                                     manual_we,
  input  logic [TRIM_W-1:0]                        manual_code,
  output logic [N_CH*TRIM_W-1:0]                   trim_out,
  output logic                                     busy,
  output logic                                     done,
  output logic [TRIM_W-1:0]                        result,
  output logic                                     sat
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int B_W   = $clog2(TRIM_W);
  localparam int CNT_W = $clog2(SETTLE_CYC);
  localparam logic [TRIM_W-1:0] MSB_CODE    = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [TRIM_W-1:0] RST_CODE    = TRIM_W'(RESET_CODE);
  localparam logic [B_W-1:0]    BIT_MSB     = B_W'(TRIM_W - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  generate
    if (SETTLE_CYC < 2) begin : g_bad_settle
      $error("tatzel_trim_sar: SETTLE_CYC must be >= 2");
    end
    if (TRIM_W < 2) begin : g_bad_width
      $error("tatzel_trim_sar: TRIM_W must be >= 2");
    end
    if (N_CH < 1) begin : g_bad_nch
      $error("tatzel_trim_sar: N_CH must be >= 1");
    end
  endgenerate

  trim_state_e       state_q;
  logic [TRIM_W-1:0] code_q [N_CH];
  logic [CH_W-1:0]   ch_q;
  logic [TRIM_W-1:0] save_q;
  logic [B_W-1:0]    bit_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cmp_s;
  logic              sel_ok;
  logic [TRIM_W-1:0] sample_code;
  logic              sample_sat;

  tatzel_sync2 u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_s)
  );

  assign sel_ok = (32'(ch_sel) < 32'(N_CH));

  // Code after the current bit decision: drop the trial bit on a low
  // comparator, then raise the next trial bit if one remains.
  always_comb begin
    sample_code = code_q[ch_q];
    if (!cmp_s) begin
      sample_code[bit_q] = 1'b0;
    end
    if (bit_q != '0) begin
      sample_code[bit_q - 1'b1] = 1'b1;
    end
    sample_sat = (sample_code == '0) || (&sample_code);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int k = 0; k < N_CH; k++) begin
        code_q[k] <= RST_CODE;
      end
      ch_q   <= '0;
      save_q <= '0;
      bit_q  <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && sel_ok) begin
            ch_q           <= ch_sel;
            save_q         <= code_q[ch_sel];
            code_q[ch_sel] <= MSB_CODE;
            bit_q          <= BIT_MSB;
            cnt_q          <= SETTLE_LOAD;
            busy           <= 1'b1;
            state_q        <= SETTLE;
          end else if (manual_we && sel_ok) begin
            code_q[ch_sel] <= manual_code;
          end
        end
        SETTLE: begin
          if (abort) begin
            code_q[ch_q] <= save_q;
            busy         <= 1'b0;
            state_q      <= IDLE;
          end else if (cnt_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            code_q[ch_q] <= save_q;
            busy         <= 1'b0;
            state_q      <= IDLE;
          end else begin
            code_q[ch_q] <= sample_code;
            if (bit_q != '0) begin
              bit_q   <= bit_q - 1'b1;
              cnt_q   <= SETTLE_LOAD;
              state_q <= SETTLE;
            end else begin
              result  <= sample_code;
              sat     <= sample_sat;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_trim_out
      assign trim_out[ch_lsb(k, TRIM_W) +: TRIM_W] = code_q[k];
    end
  endgenerate

endmodule
